tlul_led_host: RTL and testbench

Upstream TileLink-UL host stage that feeds the LED slave. Accepts a byte on a valid/ready front end and turns it into a single-beat TL-UL PutFullData to the LED register. Waits for the slave's AccessAck and reports completion, error or timeout. Optionally reads the register back with a Get and compares.

---
 rtl/tlul_led_host_if.sv | 48 ++++
 rtl/tlul_led_host.sv | 218 +++++++++++++++++++++
 tb/tb_tlul_led_host.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlul_led_host_if.sv
// tlul_led_host_if
// ----------------
// TileLink-UL channel bundle between the LED host stage and the LED slave.
//
// Signals:
//   A channel : o_a_valid, i_a_ready, o_a_opcode[2:0], o_a_param[2:0],
//               o_a_size[1:0], o_a_source, o_a_address[31:0],
//               o_a_mask[3:0], o_a_data[31:0]
//   D channel : i_d_valid, o_d_ready, i_d_opcode[2:0], i_d_source,
//               i_d_data[31:0], i_d_error
//
// Modports:
//   master : host side (drives A channel and d_ready)
//   slave  : LED register side (drives a_ready and the D channel)
//
// The o_/i_ prefixes are always relative to the host.
`timescale 1ns/1ps

interface tlul_led_host_if;
  logic        o_a_valid;
  logic        i_a_ready;
  logic [2:0]  o_a_opcode;
  logic [2:0]  o_a_param;
  logic [1:0]  o_a_size;
  logic        o_a_source;
  logic [31:0] o_a_address;
  logic [3:0]  o_a_mask;
  logic [31:0] o_a_data;

  logic        i_d_valid;
  logic        o_d_ready;
  logic [2:0]  i_d_opcode;
  logic        i_d_source;
  logic [31:0] i_d_data;
  logic        i_d_error;

  modport master (
    output o_a_valid, o_a_opcode, o_a_param, o_a_size, o_a_source,
           o_a_address, o_a_mask, o_a_data, o_d_ready,
    input  i_a_ready, i_d_valid, i_d_opcode, i_d_source, i_d_data, i_d_error
  );

  modport slave (
    input  o_a_valid, o_a_opcode, o_a_param, o_a_size, o_a_source,
           o_a_address, o_a_mask, o_a_data, o_d_ready,
    output i_a_ready, i_d_valid, i_d_opcode, i_d_source, i_d_data, i_d_error
  );
endinterface

// File: rtl/tlul_led_host.sv
// tlul_led_host
// -------------
// Upstream TL-UL host stage for the LED slave. A byte accepted on the
// valid/ready front end becomes one single-beat PutFullData to LED_ADDR.
// The host waits for the AccessAck and reports completion, error or
// timeout. With readback compiled in, a Get follows and the returned low
// byte is compared with the written one.
//
// Parameters:
//   LED_ADDR       byte address of the LED register
//   SOURCE_ID      source tag driven on A and expected on D
//   TIMEOUT_CYCLES cycles allowed in a wait state (>= 2)
//
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset
//   i_valid/i_data  byte request; accepted when i_valid && o_ready
//   o_ready         host idle
//   tl              TL-UL A/D channels (master modport)
//   o_done          one-cycle pulse, transaction finished cleanly
//   o_err           one-cycle pulse, transaction finished with error
//   o_err_code      1 slave error/bad response, 2 timeout, 3 readback
//                   mismatch; held until the next accept
//   o_rdata         last readback byte, held (0 without readback)
//
// Configuration macro:
//   TLUL_LED_HOST_READBACK_EN  compiles in the GET_REQ/GET_WAIT path.
`timescale 1ns/1ps

module tlul_led_host #(
  parameter logic [31:0] LED_ADDR       = 32'h0000_0000,
  parameter logic        SOURCE_ID      = 1'b0,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic [7:0]            i_data,
  output logic                  o_ready,
  tlul_led_host_if.master       tl,
  output logic                  o_done,
  output logic                  o_err,
  output logic [1:0]            o_err_code,
  output logic [7:0]            o_rdata
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_ACK      = 3'd0;
  localparam logic [1:0] CODE_BAD    = 2'd1;
  localparam logic [1:0] CODE_TMO    = 2'd2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PUT_REQ  = 3'd1,
    PUT_WAIT = 3'd2
`ifdef TLUL_LED_HOST_READBACK_EN
    ,
    GET_REQ  = 3'd3,
    GET_WAIT = 3'd4
`endif
  } state_t;

  state_t            state, state_next;
  logic [7:0]        byte_q, byte_next;
  logic [CNT_W-1:0]  wait_cnt, cnt_next;
  logic              done_next, err_next;
  logic [1:0]        code_next;
  logic              in_req, in_wait, is_get;
  logic              resp_meta_ok, timed_out;

  // Source match and no slave error are common to both response kinds;
  // the expected opcode is checked per wait state.
  assign resp_meta_ok = (tl.i_d_source == SOURCE_ID) && !tl.i_d_error;
  assign timed_out    = (wait_cnt == CNT_LAST);

`ifdef TLUL_LED_HOST_READBACK_EN
  localparam logic [2:0] OP_ACK_DATA   = 3'd1;
  localparam logic [1:0] CODE_MISMATCH = 2'd3;

  logic [7:0] rdata_q, rdata_next;
  logic       unused_d_hi;

  assign in_req      = (state == PUT_REQ)  || (state == GET_REQ);
  assign in_wait     = (state == PUT_WAIT) || (state == GET_WAIT);
  assign is_get      = (state == GET_REQ)  || (state == GET_WAIT);
  assign o_rdata     = rdata_q;
  assign unused_d_hi = ^tl.i_d_data[31:8];
`else
  logic unused_d_data;

  assign in_req        = (state == PUT_REQ);
  assign in_wait       = (state == PUT_WAIT);
  assign is_get        = 1'b0;
  assign o_rdata       = 8'h00;
  assign unused_d_data = ^tl.i_d_data;
`endif

  // A-channel fields come only from the state and the captured byte, so
  // they stay stable while a beat is stalled by i_a_ready.
  assign o_ready        = (state == IDLE);
  assign tl.o_a_valid   = in_req;
  assign tl.o_d_ready   = in_wait;
  assign tl.o_a_opcode  = is_get ? OP_GET : OP_PUT_FULL;
  assign tl.o_a_param   = 3'd0;
  assign tl.o_a_size    = 2'd0;
  assign tl.o_a_source  = SOURCE_ID;
  assign tl.o_a_address = LED_ADDR;
  assign tl.o_a_mask    = 4'b0001;
  assign tl.o_a_data    = is_get ? 32'h0 : {24'h0, byte_q};

  // State and status registers; reset abandons any transaction in flight
  // without emitting a completion pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      byte_q     <= 8'h00;
      wait_cnt   <= '0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      o_err_code <= 2'd0;
`ifdef TLUL_LED_HOST_READBACK_EN
      rdata_q    <= 8'h00;
`endif
    end else begin
      state      <= state_next;
      byte_q     <= byte_next;
      wait_cnt   <= cnt_next;
      o_done     <= done_next;
      o_err      <= err_next;
      o_err_code <= code_next;
`ifdef TLUL_LED_HOST_READBACK_EN
      rdata_q    <= rdata_next;
`endif
    end
  end

  // Next-state logic. The wait counter defaults to zero, so it is cleared
  // on every entry into a wait state and only advances while waiting
  // without a response.
  always_comb begin
    state_next = state;
    byte_next  = byte_q;
    cnt_next   = '0;
    done_next  = 1'b0;
    err_next   = 1'b0;
    code_next  = o_err_code;
`ifdef TLUL_LED_HOST_READBACK_EN
    rdata_next = rdata_q;
`endif
    case (state)
      IDLE: begin
        if (i_valid) begin
          byte_next  = i_data;
          code_next  = 2'd0;
          state_next = PUT_REQ;
        end
      end
      PUT_REQ: begin
        if (tl.i_a_ready) state_next = PUT_WAIT;
      end
      PUT_WAIT: begin
        if (tl.i_d_valid) begin
          if (resp_meta_ok && (tl.i_d_opcode == OP_ACK)) begin
`ifdef TLUL_LED_HOST_READBACK_EN
            state_next = GET_REQ;
`else
            done_next  = 1'b1;
            state_next = IDLE;
`endif
          end else begin
            err_next   = 1'b1;
            code_next  = CODE_BAD;
            state_next = IDLE;
          end
        end else if (timed_out) begin
          err_next   = 1'b1;
          code_next  = CODE_TMO;
          state_next = IDLE;
        end else begin
          cnt_next = wait_cnt + CNT_W'(1);
        end
      end
`ifdef TLUL_LED_HOST_READBACK_EN
      GET_REQ: begin
        if (tl.i_a_ready) state_next = GET_WAIT;
      end
      GET_WAIT: begin
        if (tl.i_d_valid) begin
          state_next = IDLE;
          if (resp_meta_ok && (tl.i_d_opcode == OP_ACK_DATA)) begin
            rdata_next = tl.i_d_data[7:0];
            if (tl.i_d_data[7:0] == byte_q) begin
              done_next = 1'b1;
            end else begin
              err_next  = 1'b1;
              code_next = CODE_MISMATCH;
            end
          end else begin
            err_next  = 1'b1;
            code_next = CODE_BAD;
          end
        end else if (timed_out) begin
          err_next   = 1'b1;
          code_next  = CODE_TMO;
          state_next = IDLE;
        end else begin
          cnt_next = wait_cnt + CNT_W'(1);
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tlul_led_host.sv
// tb_tlul_led_host
// ----------------
// Bench for tlul_led_host. Plays the LED slave on the TL-UL interface and
// predicts each transaction's outcome (done or error code, readback byte)
// from the protocol rules. Readback expectations follow the
// TLUL_LED_HOST_READBACK_EN macro.
`timescale 1ns/1ps

module tb_tlul_led_host;

  localparam int          T    = 12;
  localparam logic [31:0] ADDR = 32'h4000_0010;
  localparam logic        SRC  = 1'b1;
`ifdef TLUL_LED_HOST_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  typedef struct {
    logic [7:0]  data;
    int          aWait;
    int          dWait;
    logic [2:0]  dOp;
    logic        dSrc;
    logic        dErr;
    int          gaWait;
    int          gdWait;
    logic [2:0]  gOp;
    logic        gSrc;
    logic        gErr;
    logic [31:0] gData;
  } txn_t;

  logic       i_clk;
  logic       i_reset;
  logic       i_valid;
  logic [7:0] i_data;
  logic       o_ready;
  logic       o_done;
  logic       o_err;
  logic [1:0] o_err_code;
  logic [7:0] o_rdata;

  tlul_led_host_if tl ();

  tlul_led_host #(
    .LED_ADDR       (ADDR),
    .SOURCE_ID      (SRC),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .o_ready    (o_ready),
    .tl         (tl),
    .o_done     (o_done),
    .o_err      (o_err),
    .o_err_code (o_err_code),
    .o_rdata    (o_rdata)
  );

  int         checkCount = 0;
  int         passCount  = 0;
  int         failCount  = 0;
  logic [7:0] modelRdata = 8'h00;
  logic [1:0] modelCode  = 2'd0;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before the bench finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checkCount++;
    assert (obs === exp) begin
      passCount++;
    end else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic txn_t goodTxn(input logic [7:0] d);
    txn_t t;
    t.data   = d;
    t.aWait  = 0;
    t.dWait  = 0;
    t.dOp    = 3'd0;
    t.dSrc   = SRC;
    t.dErr   = 1'b0;
    t.gaWait = 0;
    t.gdWait = 0;
    t.gOp    = 3'd1;
    t.gSrc   = SRC;
    t.gErr   = 1'b0;
    t.gData  = {24'h0, d};
    return t;
  endfunction

  function automatic txn_t randTxn();
    txn_t        t;
    logic [31:0] r;
    t        = goodTxn(8'($urandom));
    r        = $urandom;
    t.aWait  = int'($urandom_range(0, 3));
    t.dWait  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(T - 2, T + 1)) : int'($urandom_range(0, 3));
    if ($urandom_range(0, 7) == 0) t.dOp = 3'($urandom);
    if ($urandom_range(0, 9) == 0) t.dSrc = ~SRC;
    if ($urandom_range(0, 9) == 0) t.dErr = 1'b1;
    t.gaWait = int'($urandom_range(0, 3));
    t.gdWait = ($urandom_range(0, 5) == 0) ? int'($urandom_range(T - 2, T + 1)) : int'($urandom_range(0, 3));
    if ($urandom_range(0, 7) == 0) t.gOp = 3'($urandom);
    if ($urandom_range(0, 9) == 0) t.gSrc = ~SRC;
    if ($urandom_range(0, 9) == 0) t.gErr = 1'b1;
    t.gData  = ($urandom_range(0, 2) == 0) ? r : {r[31:8], t.data};
    return t;
  endfunction

  // Reference outcome: a response arriving d cycles into a wait state is
  // taken while d < T; otherwise the wait times out.
  function automatic void predict(input txn_t t, input logic [7:0] prevR,
                                  output bit done, output logic [1:0] code,
                                  output bit getPhase, output logic [7:0] rd);
    done = 1'b0; code = 2'd0; getPhase = 1'b0; rd = prevR;
    if (t.dWait >= T) code = 2'd2;
    else if (t.dOp != 3'd0 || t.dSrc != SRC || t.dErr) code = 2'd1;
    else if (!RB) done = 1'b1;
    else begin
      getPhase = 1'b1;
      if (t.gdWait >= T) code = 2'd2;
      else if (t.gOp != 3'd1 || t.gSrc != SRC || t.gErr) code = 2'd1;
      else begin
        rd = t.gData[7:0];
        if (rd == t.data) done = 1'b1;
        else code = 2'd3;
      end
    end
  endfunction

  task automatic applyStimulusReset();
    i_reset = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset    = 1'b0;
    modelCode  = 2'd0;
    modelRdata = 8'h00;
  endtask

  task automatic idleCheck(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      #1;
      checkOutput(tag, {o_ready, o_done, o_err, o_err_code, o_rdata, tl.o_a_valid, tl.o_d_ready},
                  {1'b1, 1'b0, 1'b0, modelCode, modelRdata, 1'b0, 1'b0});
    end
  endtask

  task automatic aPhase(input string tag, input logic [2:0] op, input logic [31:0] data, input int waitCycles);
    for (int c = 0; c <= waitCycles; c++) begin
      tl.i_a_ready = (c == waitCycles);
      checkOutput({tag, "_a"},
                  {tl.o_a_valid, tl.o_a_opcode, tl.o_a_param, tl.o_a_size, tl.o_a_source,
                   tl.o_a_address, tl.o_a_mask, tl.o_a_data, tl.o_d_ready, o_ready},
                  {1'b1, op, 3'd0, 2'd0, SRC, ADDR, 4'b0001, data, 1'b0, 1'b0});
      @(posedge i_clk);
      #1;
    end
    tl.i_a_ready = 1'b0;
  endtask

  task automatic playD(input string tag, input int delay, input logic [2:0] op,
                       input logic src, input logic err, input logic [31:0] data);
    for (int c = 0; c < T; c++) begin
      checkOutput({tag, "_wait"}, {tl.o_d_ready, tl.o_a_valid, o_ready, o_done, o_err}, 5'b10000);
      if (c == delay) begin
        tl.i_d_valid  = 1'b1;
        tl.i_d_opcode = op;
        tl.i_d_source = src;
        tl.i_d_error  = err;
        tl.i_d_data   = data;
        @(posedge i_clk);
        #1;
        tl.i_d_valid  = 1'b0;
        tl.i_d_opcode = 3'($urandom);
        tl.i_d_data   = $urandom;
        break;
      end
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input string tag, input txn_t t);
    bit         expDone, getPhase;
    logic [1:0] expCode;
    logic [7:0] expRdata;
    predict(t, modelRdata, expDone, expCode, getPhase, expRdata);
    i_valid = 1'b1;
    i_data  = t.data;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_data  = 8'($urandom);
    checkOutput({tag, "_accept"}, {o_ready, o_done, o_err, o_err_code, tl.o_a_valid, tl.o_d_ready},
                {1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0});
    aPhase({tag, "_put"}, 3'd0, {24'h0, t.data}, t.aWait);
    playD({tag, "_put"}, t.dWait, t.dOp, t.dSrc, t.dErr, {24'($urandom), 8'($urandom)});
    if (getPhase) begin
      aPhase({tag, "_get"}, 3'd4, 32'h0, t.gaWait);
      playD({tag, "_get"}, t.gdWait, t.gOp, t.gSrc, t.gErr, t.gData);
    end
    modelRdata = expRdata;
    modelCode  = expCode;
    checkOutput({tag, "_end"},
                {o_ready, o_done, o_err, o_err_code, o_rdata, tl.o_a_valid, tl.o_d_ready},
                {1'b1, expDone, ~expDone, expCode, expRdata, 1'b0, 1'b0});
  endtask

  initial begin
    txn_t t;
    i_reset       = 1'b0;
    i_valid       = 1'b0;
    i_data        = 8'h00;
    tl.i_a_ready  = 1'b0;
    tl.i_d_valid  = 1'b0;
    tl.i_d_opcode = 3'd0;
    tl.i_d_source = 1'b0;
    tl.i_d_data   = 32'h0;
    tl.i_d_error  = 1'b0;

    applyStimulusReset();
    checkOutput("reset", {o_ready, tl.o_a_valid, tl.o_d_ready, o_done, o_err, o_err_code, o_rdata},
                {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00});
    idleCheck("idle", 2);

    t = goodTxn(8'hA5);
    applyStimulus("a5", t);
    idleCheck("a5_pulse", 1);

    t = goodTxn(8'h3C);
    t.aWait = 4;
    applyStimulus("stall3c", t);

    t = goodTxn(8'h77);
    t.dErr = 1'b1;
    applyStimulus("slverr", t);
    idleCheck("slverr_hold", 1);
    applyStimulus("after_err01", goodTxn(8'h01));

    t = goodTxn(8'h5A);
    t.gData = 32'hABCD_EF5A;
    applyStimulus("rb5a", t);

    t = goodTxn(8'h42);
    t.dWait = 1000;
    applyStimulus("timeout", t);
    idleCheck("timeout_hold", 2);

    t = goodTxn(8'h43);
    t.dWait = T - 1;
    applyStimulus("late_ack", t);

    applyStimulusReset();
    checkOutput("reset2", {o_ready, o_err_code, o_rdata, o_done, o_err}, {1'b1, 2'd0, 8'h00, 1'b0, 1'b0});

    t = goodTxn(8'h5A);
    t.gData = 32'h0000_0000;
    applyStimulus("rbmis", t);
    t = goodTxn(8'h99);
    t.gOp = 3'd0;
    applyStimulus("rbbadop", t);

    tl.i_d_valid  = 1'b1;
    tl.i_d_opcode = 3'd0;
    tl.i_d_source = SRC;
    tl.i_d_error  = 1'b0;
    idleCheck("stray_d", 2);
    tl.i_d_valid = 1'b0;

    i_valid = 1'b1;
    i_data  = 8'hC3;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    checkOutput("rstreq_pre", {tl.o_a_valid, o_ready}, 2'b10);
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    i_reset    = 1'b0;
    modelCode  = 2'd0;
    modelRdata = 8'h00;
    checkOutput("rstreq_post", {o_ready, tl.o_a_valid, tl.o_d_ready, o_done, o_err, o_err_code, o_rdata},
                {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00});
    idleCheck("rstreq_idle", 2);

    i_valid = 1'b1;
    i_data  = 8'hC4;
    @(posedge i_clk);
    #1;
    i_valid      = 1'b0;
    tl.i_a_ready = 1'b1;
    @(posedge i_clk);
    #1;
    tl.i_a_ready = 1'b0;
    checkOutput("rstwait_pre", {tl.o_d_ready, tl.o_a_valid}, 2'b10);
    tl.i_d_valid  = 1'b1;
    tl.i_d_opcode = 3'd0;
    tl.i_d_source = SRC;
    tl.i_d_error  = 1'b0;
    i_reset       = 1'b1;
    @(posedge i_clk);
    #1;
    i_reset      = 1'b0;
    tl.i_d_valid = 1'b0;
    checkOutput("rstwait_post", {o_ready, tl.o_a_valid, tl.o_d_ready, o_done, o_err, o_err_code},
                {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0});
    idleCheck("rstwait_idle", 2);

    for (int i = 0; i < 40; i++) begin
      applyStimulus($sformatf("rand%0d", i), randTxn());
    end
    idleCheck("final", 2);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
